// File: rtl/axis_ram_scheduler_if.sv
// Stream bundle around the scheduler.
//   s_axis_* : N_SRC producer lanes, lane i on tdata[i*DATA_W +: DATA_W]
//   m_axis_* : single merged stream toward the bin RAM slave port
// Modports:
//   master : scheduler side (accepts s_axis lanes, drives m_axis)
//   slave  : environment side (drives producer lanes, sinks m_axis)
interface axis_ram_scheduler_if #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC*DATA_W-1:0] s_axis_tdata;
  logic [N_SRC-1:0]        s_axis_tvalid;
  logic [N_SRC-1:0]        s_axis_tready;
  logic [DATA_W-1:0]       m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic [SRC_W-1:0]        m_axis_tuser;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser
  );
endinterface

// File: rtl/axis_ram_scheduler.sv
// Round-robin scheduler merging N_SRC producers into the bin RAM stream.
// Frames of FRAME_LEN beats, bursts of at most MAX_BURST beats per grant.
// Ports:
//   aclk, areset       clock / async active-high reset
//   start              one-cycle pulse, begins a frame when idle
//   busy               high from accepted start until frame_done
//   frame_done         one-cycle pulse after last beat leaves m_axis
//   beat_count         beats accepted in current/last frame
//   bus (master)       s_axis lanes in, registered m_axis out, tuser = source index
//
// state | meaning
// IDLE  | waiting for start
// ARB   | picking next valid source from rr_ptr (input bubble cycle)
// XFER  | moving beats from the granted source
// DRAIN | last beat of frame held in output register
// DONE  | frame_done pulse, back to IDLE
module axis_ram_scheduler #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int FRAME_LEN = 256,
  localparam int SRC_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] beat_count,
  axis_ram_scheduler_if.master bus
);

  if (FRAME_LEN < 1 || FRAME_LEN > 65535 || MAX_BURST < 1 || MAX_BURST > 255 ||
      N_SRC < 2 || N_SRC > 8) begin : g_bad_param
    $error("axis_ram_scheduler: illegal FRAME_LEN, MAX_BURST or N_SRC");
  end

  typedef enum logic [2:0] {IDLE, ARB, XFER, DRAIN, DONE} state_t;

  state_t           state;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant;
  logic [7:0]       burst_cnt;

  logic [SRC_W-1:0] arb_idx;
  logic             arb_found;
  logic [SRC_W:0]   idx_w;
  logic [SRC_W-1:0] next_ptr;
  logic             out_free;
  logic             accept;
  logic             m_hs;
  logic             src_gap;
  logic             last_beat;
  logic             burst_end;

  // First valid source at or after rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    idx_w     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!arb_found) begin
        idx_w = {1'b0, rr_ptr} + (SRC_W+1)'(k);
        if (idx_w >= (SRC_W+1)'(N_SRC)) idx_w = idx_w - (SRC_W+1)'(N_SRC);
        if (bus.s_axis_tvalid[idx_w[SRC_W-1:0]]) begin
          arb_found = 1'b1;
          arb_idx   = idx_w[SRC_W-1:0];
        end
      end
    end
  end

  assign next_ptr  = (grant == SRC_W'(N_SRC - 1)) ? '0 : grant + 1'b1;
  assign out_free  = !bus.m_axis_tvalid || bus.m_axis_tready;
  assign m_hs      = bus.m_axis_tvalid && bus.m_axis_tready;
  assign accept    = (state == XFER) && out_free && bus.s_axis_tvalid[grant];
  assign src_gap   = (state == XFER) && out_free && !bus.s_axis_tvalid[grant];
  assign last_beat = (beat_count + 16'd1) == 16'(FRAME_LEN);
  assign burst_end = (burst_cnt + 8'd1) == 8'(MAX_BURST);

  // Ready only toward the granted source, and only when the output slot frees up.
  always_comb begin
    bus.s_axis_tready = '0;
    if (state == XFER && out_free) bus.s_axis_tready[grant] = 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      grant             <= '0;
      burst_cnt         <= '0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      beat_count        <= '0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tuser  <= '0;
    end else begin
      frame_done <= 1'b0;

      // A load in the same cycle as a handshake keeps tvalid high: 1 beat/cycle.
      if (accept) begin
        bus.m_axis_tdata  <= bus.s_axis_tdata[int'(grant)*DATA_W +: DATA_W];
        bus.m_axis_tuser  <= grant;
        bus.m_axis_tvalid <= 1'b1;
      end else if (m_hs) begin
        bus.m_axis_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            beat_count <= '0;
            state      <= ARB;
          end
        end
        ARB: begin
          if (arb_found) begin
            grant     <= arb_idx;
            burst_cnt <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            beat_count <= beat_count + 16'd1;
            burst_cnt  <= burst_cnt + 8'd1;
          end
          // Frame end wins over burst end.
          if (accept && last_beat) begin
            rr_ptr <= next_ptr;
            state  <= DRAIN;
          end else if ((accept && burst_end) || src_gap) begin
            rr_ptr <= next_ptr;
            state  <= ARB;
          end
        end
        DRAIN: begin
          if (!bus.m_axis_tvalid || m_hs) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_ram_scheduler.sv
// Bench for axis_ram_scheduler: N_SRC=4, MAX_BURST=2, FRAME_LEN=16.
// Producers are modelled as per-source queues; expected beats are pushed by
// hand into a scoreboard queue and a monitor pops them on every m_axis handshake.
module tb_axis_ram_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 2;
  localparam int FL = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic [15:0] beat_count;

  axis_ram_scheduler_if #(.N_SRC(N), .DATA_W(DW)) sif ();

  axis_ram_scheduler #(
    .N_SRC(N), .DATA_W(DW), .MAX_BURST(MB), .FRAME_LEN(FL)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .beat_count (beat_count),
    .bus        (sif)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mon_cnt  = 0;
  int done_cnt = 0;
  int last_hs  = 0;
  int hs_log[$];
  logic [DW-1:0] src_q[N][$];
  logic [DW+1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_beat(input int s, input logic [DW-1:0] d);
    logic [1:0] u;
    u = s[1:0];
    exp_q.push_back({u, d});
  endtask

  // Producer model: only writer of s_axis_tvalid/tdata.
  initial begin
    logic [N-1:0] fire;
    sif.s_axis_tvalid = '0;
    sif.s_axis_tdata  = '0;
    forever begin
      @(negedge aclk);
      fire = sif.s_axis_tvalid & sif.s_axis_tready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          sif.s_axis_tvalid[i]          = 1'b1;
          sif.s_axis_tdata[i*DW +: DW] = src_q[i][0];
        end else begin
          sif.s_axis_tvalid[i]          = 1'b0;
          sif.s_axis_tdata[i*DW +: DW] = '0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [DW+1:0] e;
    forever begin
      @(negedge aclk);
      cyc++;
      check("tready_onehot0", 64'($onehot0(sif.s_axis_tready)), 64'd1);
      if (sif.m_axis_tvalid && sif.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h src %0d want no beat", sif.m_axis_tdata,
                   sif.m_axis_tuser);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(sif.m_axis_tdata), 64'(e[DW-1:0]));
          check("beat_src", 64'(sif.m_axis_tuser), 64'(e[DW+1:DW]));
        end
        mon_cnt++;
        last_hs = cyc;
        hs_log.push_back(cyc);
      end
      if (frame_done) begin
        done_cnt++;
        check("done_latency", 64'(cyc - last_hs), 64'd1);
        check("done_beat_count", 64'(beat_count), 64'(FL));
        check("done_all_delivered", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic sync(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic pulse_start();
    sync(1);
    start = 1'b1;
    sync(1);
    start = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int d0);
    int c;
    c = 0;
    while (done_cnt == d0 && c < 300) begin
      sync(1);
      c++;
    end
    if (done_cnt == d0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no frame_done want frame_done within 300 cycles", name);
    end
    sync(3);
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    check({name, "_beat_count"}, 64'(beat_count), 64'(FL));
  endtask

  task automatic wait_hs(input string name, input int target);
    int c;
    c = 0;
    while (mon_cnt < target && c < 100) begin
      sync(1);
      c++;
    end
    if (mon_cnt < target) begin
      total++;
      bad++;
      $display("FAIL %s_hs_timeout: got %0d handshakes want %0d", name, mon_cnt, target);
    end
  endtask

  // All four sources, 4 beats each: bursts of 2 in order 0,1,2,3,0,1,2,3.
  task automatic run_all_sources(input string name);
    int d0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4; j++) src_q[i].push_back(32'hA000_0000 + 32'(i * 256 + j));
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < 2; j++) expect_beat(i, 32'hA000_0000 + 32'(i * 256 + 2 * k + j));
    hs_log.delete();
    d0 = done_cnt;
    pulse_start();
    finish_frame(name, d0);
    check({name, "_hs_count"}, 64'(hs_log.size()), 64'd16);
    // 8 bursts of 2 beats with one arbitration bubble between bursts.
    check({name, "_span"}, 64'(hs_log[15] - hs_log[0]), 64'd22);
  endtask

  initial begin
    int d0;
    int base;
    areset = 1'b1;
    start  = 1'b0;
    sif.m_axis_tready = 1'b0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_beat_count", 64'(beat_count), 64'd0);
    check("rst_m_tvalid", 64'(sif.m_axis_tvalid), 64'd0);
    check("rst_m_tdata", 64'(sif.m_axis_tdata), 64'd0);
    check("rst_m_tuser", 64'(sif.m_axis_tuser), 64'd0);
    check("rst_s_tready", 64'(sif.s_axis_tready), 64'd0);
    sync(1);
    areset = 1'b0;
    sif.m_axis_tready = 1'b1;
    sync(3);
    check("idle_busy", 64'(busy), 64'd0);

    // Round robin across all sources from rr_ptr=0.
    run_all_sources("rr");

    // Single source; rr_ptr is now 0 (last grant was src3).
    for (int j = 0; j < 16; j++) begin
      src_q[0].push_back(32'h0010_2011 + 32'(j));
      expect_beat(0, 32'h0010_2011 + 32'(j));
    end
    d0 = done_cnt;
    pulse_start();
    finish_frame("single", d0);

    // Gap: rr_ptr=1, src1 has one beat, then src2/src3 alternate.
    src_q[1].push_back(32'hD100_0000);
    for (int j = 0; j < 8; j++) src_q[2].push_back(32'hD200_0000 + 32'(j));
    for (int j = 0; j < 7; j++) src_q[3].push_back(32'hD300_0000 + 32'(j));
    expect_beat(1, 32'hD100_0000);
    for (int k = 0; k < 3; k++) begin
      expect_beat(2, 32'hD200_0000 + 32'(2 * k));
      expect_beat(2, 32'hD200_0000 + 32'(2 * k + 1));
      expect_beat(3, 32'hD300_0000 + 32'(2 * k));
      expect_beat(3, 32'hD300_0000 + 32'(2 * k + 1));
    end
    expect_beat(2, 32'hD200_0006);
    expect_beat(2, 32'hD200_0007);
    expect_beat(3, 32'hD300_0006);
    d0 = done_cnt;
    pulse_start();
    finish_frame("gap", d0);

    // Backpressure mid-burst, plus a start pulse while busy.
    for (int j = 0; j < 16; j++) begin
      src_q[2].push_back(32'hC000_0000 + 32'(j));
      expect_beat(2, 32'hC000_0000 + 32'(j));
    end
    d0   = done_cnt;
    base = mon_cnt;
    pulse_start();
    wait_hs("stall", base + 3);
    sif.m_axis_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      if (sif.m_axis_tvalid) begin
        check("stall_data", 64'(sif.m_axis_tdata), 64'(exp_q[0][DW-1:0]));
        check("stall_s_tready", 64'(sif.s_axis_tready), 64'd0);
      end
    end
    check("stall_valid", 64'(sif.m_axis_tvalid), 64'd1);
    sync(1);
    sif.m_axis_tready = 1'b1;
    pulse_start();
    finish_frame("stall", d0);
    sync(20);
    check("ignored_start_busy", 64'(busy), 64'd0);
    check("ignored_start_done", 64'(done_cnt - d0), 64'd1);

    // Async reset while an output beat is held in XFER.
    for (int j = 0; j < 16; j++) src_q[0].push_back(32'hF000_0000 + 32'(j));
    sif.m_axis_tready = 1'b0;
    d0 = done_cnt;
    pulse_start();
    sync(6);
    check("pre_rst_valid", 64'(sif.m_axis_tvalid), 64'd1);
    check("pre_rst_data", 64'(sif.m_axis_tdata), 64'hF000_0000);
    check("pre_rst_busy", 64'(busy), 64'd1);
    @(negedge aclk);
    #2;
    areset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_m_tvalid", 64'(sif.m_axis_tvalid), 64'd0);
    check("arst_m_tdata", 64'(sif.m_axis_tdata), 64'd0);
    check("arst_m_tuser", 64'(sif.m_axis_tuser), 64'd0);
    check("arst_s_tready", 64'(sif.s_axis_tready), 64'd0);
    check("arst_beat_count", 64'(beat_count), 64'd0);
    check("arst_frame_done", 64'(frame_done), 64'd0);
    sync(2);
    areset = 1'b0;
    src_q[0].delete();
    sif.m_axis_tready = 1'b1;
    sync(10);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_m_tvalid", 64'(sif.m_axis_tvalid), 64'd0);
    check("post_rst_no_done", 64'(done_cnt - d0), 64'd0);

    // Restart after reset: rr_ptr back at 0.
    run_all_sources("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1);
  end

endmodule
